// File: rtl/rx_bit_sequencer.sv
// rtl/rx_bit_sequencer.sv - receive frame timing: start/data/stop sequencing with mid-bit strobes
module rx_bit_sequencer #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_BIT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start_detected,
  input  logic                    serial_in,
  input  logic [NUM_CNT_BITS-1:0] clks_per_bit,
  input  logic [NUM_BIT_BITS-1:0] num_data_bits,
  input  logic                    abort,
  output logic                    busy,
  output logic                    sample_strobe,
  output logic                    shift_strobe,
  output logic [NUM_BIT_BITS-1:0] bit_index,
  output logic                    frame_done,
  output logic                    framing_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_CNT_BITS-1:0] c_q, c_d;
  logic [NUM_BIT_BITS-1:0] n_q, n_d;
  logic [NUM_BIT_BITS-1:0] bit_index_q, bit_index_d;
  logic                    frame_done_q, frame_done_d;
  logic                    framing_error_q, framing_error_d;

  logic [NUM_CNT_BITS-1:0] half;
  logic                    cnt_wrap;

  // Strobes decode registered state only, so serial_in never reaches them combinationally.
  assign half          = c_q >> 1;
  assign cnt_wrap      = (cnt_q == c_q);
  assign sample_strobe = (state_q != IDLE) && (cnt_q == half);
  assign shift_strobe  = (state_q == DATA) && sample_strobe;

  assign busy          = (state_q != IDLE);
  assign bit_index     = bit_index_q;
  assign frame_done    = frame_done_q;
  assign framing_error = framing_error_q;

  always_comb begin
    state_d         = state_q;
    c_d             = c_q;
    n_d             = n_q;
    frame_done_d    = 1'b0;
    framing_error_d = 1'b0;
    bit_index_d     = shift_strobe ? bit_index_q + NUM_BIT_BITS'(1) : bit_index_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_wrap ? NUM_CNT_BITS'(1) : cnt_q + NUM_CNT_BITS'(1);
    end

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_detected) begin
            state_d     = START;
            cnt_d       = NUM_CNT_BITS'(1);
            bit_index_d = '0;
            c_d         = (clks_per_bit < NUM_CNT_BITS'(2)) ? NUM_CNT_BITS'(2) : clks_per_bit;
            n_d         = (num_data_bits == '0) ? NUM_BIT_BITS'(1) : num_data_bits;
          end
        end
        START: begin
          if (sample_strobe && serial_in) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_wrap) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (cnt_wrap && (bit_index_q == n_q)) begin
            state_d = STOP;
          end
        end
        STOP: begin
          // Leave at the stop sample point rather than the period end for early resync.
          if (sample_strobe) begin
            state_d         = IDLE;
            cnt_d           = '0;
            frame_done_d    = serial_in;
            framing_error_d = ~serial_in;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      c_q             <= NUM_CNT_BITS'(2);
      n_q             <= NUM_BIT_BITS'(1);
      bit_index_q     <= '0;
      frame_done_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      c_q             <= c_d;
      n_q             <= n_d;
      bit_index_q     <= bit_index_d;
      frame_done_q    <= frame_done_d;
      framing_error_q <= framing_error_d;
    end
  end

endmodule
